// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : Data-memory load/store bus between a core (master) and a
//                memory-side responder (slave). Request handshake plus a
//                single-cycle response strobe.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory-side responder for the core data port. Accepts one
//                load/store, waits WAIT_CYCLES, then pulses a one-cycle
//                response. Holds a word RAM, a read-only switch register and
//                a read/write hex-LED register.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] SW_ADDR     = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR    = 32'h0000_1004
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_responder_if.slave  bus,
    input  wire logic [9:0]  sw,
    output logic      [23:0] hex_led_data
);

    localparam int         c_aw        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;
    logic        r_err;
    logic [23:0] r_led;

    logic        w_handshake;
    logic        w_enter_resp;
    logic        w_cur_we;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic [3:0]  w_cur_be;
    logic [c_aw-1:0] w_idx;
    logic        w_sw_hit;
    logic        w_led_hit;
    logic        w_ram_sel;
    logic [31:0] w_rdata_nxt;
    logic        w_err_nxt;

    assign bus.req_ready  = (r_state == S_IDLE) && !reset;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_rdata  = r_rdata;
    assign bus.rsp_err    = r_err;
    assign hex_led_data   = r_led;

    assign w_handshake  = bus.req_valid && bus.req_ready;
    // A reset on the edge that would enter RESP drops the transaction.
    assign w_enter_resp = !reset && (r_state != S_RESP) && (w_next_state == S_RESP);

    // With zero wait states RESP is entered on the handshake edge itself, so the
    // request fields come straight from the bus while IDLE, else from the latch.
    assign w_cur_we    = (r_state == S_IDLE) ? bus.req_we    : r_we;
    assign w_cur_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;
    assign w_cur_be    = (r_state == S_IDLE) ? bus.req_be    : r_be;

    assign w_idx     = w_cur_addr[c_aw+1:2];
    assign w_sw_hit  = (w_cur_addr == SW_ADDR);
    assign w_led_hit = (w_cur_addr == LED_ADDR);
    assign w_ram_sel = (w_cur_addr[1:0] == 2'b00) && (w_cur_addr[31:2] < 30'(DEPTH_WORDS))
                       && !w_sw_hit && !w_led_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_handshake) w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Response data and error decode for the current transaction.
    always_comb begin
        w_rdata_nxt = 32'd0;
        w_err_nxt   = 1'b0;
        if (w_cur_we && (w_cur_be == 4'b0000)) begin
            // An empty store is a harmless no-op wherever it points.
            w_err_nxt = 1'b0;
        end else if (w_sw_hit) begin
            if (w_cur_we) w_err_nxt   = 1'b1;
            else          w_rdata_nxt = {22'd0, sw};
        end else if (w_led_hit) begin
            if (!w_cur_we) w_rdata_nxt = {8'd0, r_led};
        end else if (w_ram_sel) begin
            if (!w_cur_we) w_rdata_nxt = r_mem[w_idx];
        end else begin
            w_err_nxt = 1'b1;
        end
    end

    // Request latch, taken on the handshake edge.
    always_ff @(posedge clk) begin
        if (w_handshake) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
        end
    end

    // Wait counter, response registers and LED register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_led   <= 24'd0;
        end else begin
            if (w_handshake)
                r_cnt <= c_wait_load;
            else if ((r_state == S_WAIT) && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            if (w_enter_resp) begin
                r_rdata <= w_rdata_nxt;
                r_err   <= w_err_nxt;
                if (w_led_hit && w_cur_we) begin
                    // Only three bytes exist; be[3] has nothing to enable.
                    for (int i = 0; i < 3; i++)
                        if (w_cur_be[i]) r_led[8*i +: 8] <= w_cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // RAM byte-masked write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_ram_sel && w_cur_we) begin
            for (int i = 0; i < 4; i++)
                if (w_cur_be[i]) r_mem[w_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed bench for dmem_responder. One instance with one
//                wait state carries the functional vectors; a second with
//                three wait states checks handshake timing under held requests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic [9:0]  sw;
    logic [23:0] hex1;
    logic [23:0] hex3;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus1),
        .sw           (sw),
        .hex_led_data (hex1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus3),
        .sw           (sw),
        .hex_led_data (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // One transaction on the single-wait-state instance; checks latency and
    // response count, returns the response payload.
    task automatic txn1(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err);
        int lat;
        int nrsp;
        bit got;
        rdata = 32'd0;
        err   = 1'b0;
        @(posedge clk); #1;
        bus1.req_valid = 1'b1;
        bus1.req_we    = we;
        bus1.req_addr  = addr;
        bus1.req_wdata = wdata;
        bus1.req_be    = be;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus1.req_ready) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_hs_timeout"}, 32'd0, 32'd1);
            bus1.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        lat  = 0;
        nrsp = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid) begin
                nrsp++;
                if (lat == 0) begin
                    lat   = k;
                    rdata = bus1.rsp_rdata;
                    err   = bus1.rsp_err;
                end
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_nrsp"}, 32'(nrsp), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [11:0] rdy3;
    logic [11:0] rv3;
    int          nrv3;
    int          nrv_rst;

    initial begin
        reset          = 1'b1;
        sw             = 10'd0;
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 32'd0;
        bus1.req_wdata = 32'd0;
        bus1.req_be    = 4'd0;
        bus3.req_valid = 1'b0;
        bus3.req_we    = 1'b0;
        bus3.req_addr  = 32'd0;
        bus3.req_wdata = 32'd0;
        bus3.req_be    = 4'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", 32'(bus1.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst_hex", 32'(hex1), 32'd0);
        check("rst_rdata", bus1.rsp_rdata, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus1.req_ready), 32'd1);

        // Full-word store then load.
        txn1("st10", 1'b1, 32'h10, 32'hCAFE_BABE, 4'b1111, rd, er);
        check("st10_err", 32'(er), 32'd0);
        check("st10_rdata", rd, 32'd0);
        txn1("ld10", 1'b0, 32'h10, 32'd0, 4'b0000, rd, er);
        check("ld10_rdata", rd, 32'hCAFE_BABE);
        check("ld10_err", 32'(er), 32'd0);

        // Byte enables.
        txn1("stbe", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, rd, er);
        txn1("ldbe", 1'b0, 32'h10, 32'd0, 4'b0000, rd, er);
        check("ldbe_rdata", rd, 32'hCA22_BA44);

        // Switch and LED registers.
        sw = 10'h2A5;
        txn1("ldsw", 1'b0, 32'h1000, 32'd0, 4'b0000, rd, er);
        check("ldsw_rdata", rd, 32'h0000_02A5);
        check("ldsw_err", 32'(er), 32'd0);
        txn1("stled", 1'b1, 32'h1004, 32'hFFAB_CDEF, 4'b0111, rd, er);
        check("stled_err", 32'(er), 32'd0);
        check("stled_hex", 32'(hex1), 32'h00AB_CDEF);
        txn1("ldled", 1'b0, 32'h1004, 32'd0, 4'b0000, rd, er);
        check("ldled_rdata", rd, 32'h00AB_CDEF);
        txn1("stsw", 1'b1, 32'h1000, 32'h0000_0123, 4'b1111, rd, er);
        check("stsw_err", 32'(er), 32'd1);
        check("stsw_hex", 32'(hex1), 32'h00AB_CDEF);

        // Error decodes.
        txn1("ld13", 1'b0, 32'h13, 32'd0, 4'b0000, rd, er);
        check("ld13_err", 32'(er), 32'd1);
        check("ld13_rdata", rd, 32'd0);
        txn1("ld2000", 1'b0, 32'h2000, 32'd0, 4'b0000, rd, er);
        check("ld2000_err", 32'(er), 32'd1);
        check("ld2000_rdata", rd, 32'd0);
        txn1("stffc", 1'b1, 32'hFFC, 32'h1234_5678, 4'b1111, rd, er);
        txn1("st3ffc", 1'b1, 32'h3FFC, 32'hDEAD_BEEF, 4'b1111, rd, er);
        check("st3ffc_err", 32'(er), 32'd1);
        txn1("ldffc", 1'b0, 32'hFFC, 32'd0, 4'b0000, rd, er);
        check("ldffc_rdata", rd, 32'h1234_5678);

        // Three wait states with the request held high across two acceptances.
        @(posedge clk); #1;
        bus3.req_valid = 1'b1;
        bus3.req_we    = 1'b1;
        bus3.req_addr  = 32'h40;
        bus3.req_wdata = 32'h0BAD_F00D;
        bus3.req_be    = 4'b1111;
        nrv3 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rdy3[c] = bus3.req_ready;
            rv3[c]  = bus3.rsp_valid;
            if (bus3.rsp_valid) nrv3++;
            @(posedge clk); #1;
            if (c == 5) bus3.req_valid = 1'b0;
        end
        check("w3_ready_c0", 32'(rdy3[0]), 32'd1);
        check("w3_ready_c1_4", 32'(rdy3[4:1]), 32'd0);
        check("w3_ready_c5", 32'(rdy3[5]), 32'd1);
        check("w3_rv_pattern", 32'(rv3), 32'h210);
        check("w3_rsp_count", 32'(nrv3), 32'd2);

        // Reset during WAIT drops the store to 0x20.
        txn1("st20pre", 1'b1, 32'h20, 32'h1111_1111, 4'b1111, rd, er);
        @(posedge clk); #1;
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 32'h20;
        bus1.req_wdata = 32'h0000_0055;
        bus1.req_be    = 4'b1111;
        @(negedge clk);
        check("rst20_ready", 32'(bus1.req_ready), 32'd1);
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        reset = 1'b1;
        nrv_rst = 0;
        @(negedge clk);
        if (bus1.rsp_valid) nrv_rst++;
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid) nrv_rst++;
        end
        check("rst20_no_rsp", 32'(nrv_rst), 32'd0);
        check("rst20_hex", 32'(hex1), 32'd0);
        txn1("ld20", 1'b0, 32'h20, 32'd0, 4'b0000, rd, er);
        check("ld20_rdata", rd, 32'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
